// File: rtl/hd_xcvr_ctrl_if.sv
// Per-channel signal bundle between the UART side, the half-duplex transceiver
// pins and the direction controller. Names follow the controller's point of view.
interface hd_xcvr_ctrl_if #(
  parameter int NumChannels = 2
);
  logic [NumChannels-1:0] mode_auto_i;
  logic [NumChannels-1:0] tx_enable_i;
  logic [NumChannels-1:0] rx_enable_i;
  logic [NumChannels-1:0] tx_i;
  logic [NumChannels-1:0] rx_o;
  logic [NumChannels-1:0] di_o;
  logic [NumChannels-1:0] de_o;
  logic [NumChannels-1:0] ren_o;
  logic [NumChannels-1:0] ro_i;
  logic [NumChannels-1:0] busy_o;

  modport slave (
    input  mode_auto_i, tx_enable_i, rx_enable_i, tx_i, ro_i,
    output rx_o, di_o, de_o, ren_o, busy_o
  );

  modport master (
    output mode_auto_i, tx_enable_i, rx_enable_i, tx_i, ro_i,
    input  rx_o, di_o, de_o, ren_o, busy_o
  );
endinterface

// File: rtl/hd_xcvr_ctrl.sv
// Multi-channel half-duplex transceiver direction controller: per-channel FSM that
// sequences receiver/driver enables with break-before-make turnaround and auto-direction.
module hd_xcvr_ctrl #(
  parameter int NumChannels    = 2,
  parameter int SwitchCycles   = 5,
  parameter int EndCycles      = 5,
  parameter int AutoIdleCycles = 12
) (
  input logic           clk_i,
  input logic           rst_i,
  hd_xcvr_ctrl_if.slave bus
);

  localparam int MaxCycles = (SwitchCycles > EndCycles) ? SwitchCycles : EndCycles;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam int IdleW     = $clog2(AutoIdleCycles + 1);

  localparam logic [CntW-1:0]  SwitchLoad = CntW'(SwitchCycles - 1);
  localparam logic [CntW-1:0]  EndLoad    = CntW'(EndCycles - 1);
  localparam logic [IdleW-1:0] IdleMax    = IdleW'(AutoIdleCycles);

  typedef enum logic [2:0] {
    S_OFF,
    S_RX,
    S_TX_SETUP,
    S_TX,
    S_TX_HOLD,
    S_RX_SETUP
  } state_e;

  logic [NumChannels-1:0] rx_v;
  logic [NumChannels-1:0] di_v;
  logic [NumChannels-1:0] de_v;
  logic [NumChannels-1:0] ren_v;
  logic [NumChannels-1:0] busy_v;

  generate
    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
      state_e                  st_q, st_d;
      logic [CntW-1:0]         cnt_q, cnt_d;
      logic [IdleW-1:0]        idle_q, idle_d;
      logic [SwitchCycles-1:0] dl_q, dl_d;
      logic                    m_q;
      logic                    de_q, ren_q, busy_q;
      logic                    mode_in, tx_en, rx_en, tx_in, ro_in;
      logic                    txd, treq;

      assign mode_in = bus.mode_auto_i[gi];
      assign tx_en   = bus.tx_enable_i[gi];
      assign rx_en   = bus.rx_enable_i[gi];
      assign tx_in   = bus.tx_i[gi];
      assign ro_in   = bus.ro_i[gi];
      assign txd     = dl_q[SwitchCycles-1];

      // Auto mode: a start bit opens a transmission; once driving, only a long
      // enough idle run on the delayed data (as it leaves the pins) closes it.
      always_comb begin
        treq = tx_en;
        if (m_q) begin
          if (st_q inside {S_TX_SETUP, S_TX, S_TX_HOLD}) begin
            treq = (idle_q < IdleMax);
          end else begin
            treq = !tx_in;
          end
        end
      end

      always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        unique case (st_q)
          S_OFF: begin
            if (treq) begin
              st_d  = S_TX_SETUP;
              cnt_d = SwitchLoad;
            end else if (rx_en) begin
              st_d = S_RX;
            end
          end
          S_RX: begin
            if (treq) begin
              st_d  = S_TX_SETUP;
              cnt_d = SwitchLoad;
            end else if (!rx_en) begin
              st_d = S_OFF;
            end
          end
          S_TX_SETUP: begin
            if (cnt_q == '0) begin
              st_d = S_TX;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          S_TX: begin
            if (!treq) begin
              st_d  = S_TX_HOLD;
              cnt_d = EndLoad;
            end
          end
          S_TX_HOLD: begin
            if (treq) begin
              st_d = S_TX;
            end else if (cnt_q == '0) begin
              st_d  = S_RX_SETUP;
              cnt_d = SwitchLoad;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          S_RX_SETUP: begin
            if (treq) begin
              st_d  = S_TX_SETUP;
              cnt_d = SwitchLoad;
            end else if (cnt_q == '0) begin
              st_d = rx_en ? S_RX : S_OFF;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: begin
            st_d  = S_OFF;
            cnt_d = '0;
          end
        endcase
      end

      always_comb begin
        idle_d = idle_q;
        if (st_d == S_TX_SETUP && st_q != S_TX_SETUP) begin
          idle_d = '0;
        end else if (!txd) begin
          idle_d = '0;
        end else if (idle_q < IdleMax) begin
          idle_d = idle_q + 1'b1;
        end
      end

      always_comb begin
        dl_d    = dl_q;
        dl_d[0] = tx_in;
        for (int k = 1; k < SwitchCycles; k++) begin
          dl_d[k] = dl_q[k-1];
        end
      end

      // Outputs are registered from the next state so they change together with st_q.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          st_q   <= S_OFF;
          cnt_q  <= '0;
          idle_q <= '0;
          dl_q   <= '1;
          m_q    <= 1'b0;
          de_q   <= 1'b0;
          ren_q  <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          st_q   <= st_d;
          cnt_q  <= cnt_d;
          idle_q <= idle_d;
          dl_q   <= dl_d;
          if (st_q inside {S_OFF, S_RX}) begin
            m_q <= mode_in;
          end
          de_q   <= (st_d inside {S_TX, S_TX_HOLD});
          ren_q  <= (st_d != S_RX);
          busy_q <= !(st_d inside {S_OFF, S_RX});
        end
      end

      assign de_v[gi]   = de_q;
      assign ren_v[gi]  = ren_q;
      assign busy_v[gi] = busy_q;
      assign di_v[gi]   = de_q ? (m_q ? txd : tx_in) : 1'b1;
      assign rx_v[gi]   = ren_q ? 1'b1 : ro_in;
    end
  endgenerate

  assign bus.de_o   = de_v;
  assign bus.ren_o  = ren_v;
  assign bus.busy_o = busy_v;
  assign bus.di_o   = di_v;
  assign bus.rx_o   = rx_v;

endmodule

// File: tb/tb_hd_xcvr_ctrl.sv
// Directed bench for hd_xcvr_ctrl (2 channels, turnaround 4, hold 4, auto idle 10).
module tb_hd_xcvr_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  hd_xcvr_ctrl_if #(.NumChannels(2)) bus ();

  hd_xcvr_ctrl #(
    .NumChannels   (2),
    .SwitchCycles  (4),
    .EndCycles     (4),
    .AutoIdleCycles(10)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  // Auto-mode line level on ch1 for local cycle c: idle, 10 frame bits from 20, idle from 30.
  function automatic logic auto_tx(input int c);
    logic [9:0] frame;
    frame = 10'b0010110100;
    if (c < 20 || c >= 30) return 1'b1;
    return frame[c-20];
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    bus.mode_auto_i = 2'($urandom);
    bus.tx_enable_i = 2'($urandom);
    bus.rx_enable_i = 2'($urandom);
    bus.tx_i        = 2'($urandom);
    bus.ro_i        = 2'($urandom);
    step();
    #1;
    n_checks += 5;
    if (bus.de_o !== 2'b00)   begin n_fail++; $display("FAIL reset_de got=%b exp=00", bus.de_o); end
    if (bus.ren_o !== 2'b11)  begin n_fail++; $display("FAIL reset_ren got=%b exp=11", bus.ren_o); end
    if (bus.di_o !== 2'b11)   begin n_fail++; $display("FAIL reset_di got=%b exp=11", bus.di_o); end
    if (bus.rx_o !== 2'b11)   begin n_fail++; $display("FAIL reset_rx got=%b exp=11", bus.rx_o); end
    if (bus.busy_o !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%b exp=00", bus.busy_o); end
    $display("reset: de=%b ren=%b di=%b rx=%b busy=%b", bus.de_o, bus.ren_o, bus.di_o, bus.rx_o, bus.busy_o);
    bus.mode_auto_i = 2'b00;
    bus.tx_enable_i = 2'b00;
    bus.rx_enable_i = 2'b00;
    bus.tx_i        = 2'b11;
    bus.ro_i        = 2'b00;
    step();
    rst_i = 1'b0;
    step();
    step();
  endtask

  task automatic test_manual();
    logic e_de, e_ren, e_busy, e_di, e_rx;
    bus.rx_enable_i[0] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      step();
      bus.tx_enable_i[0] = (c >= 10 && c < 30);
      bus.tx_i[0]        = 1'((c % 2) ^ ((c / 4) % 2));
      bus.ro_i[0]        = ((c % 3) == 0);
      #1;
      e_de   = (c >= 15 && c <= 34);
      e_ren  = !((c >= 1 && c <= 10) || c >= 39);
      e_busy = (c >= 11 && c <= 38);
      e_di   = e_de ? bus.tx_i[0] : 1'b1;
      e_rx   = e_ren ? 1'b1 : bus.ro_i[0];
      n_checks += 5;
      if (bus.de_o[0] !== e_de)     begin n_fail++; $display("FAIL manual_de c=%0d got=%b exp=%b", c, bus.de_o[0], e_de); end
      if (bus.ren_o[0] !== e_ren)   begin n_fail++; $display("FAIL manual_ren c=%0d got=%b exp=%b", c, bus.ren_o[0], e_ren); end
      if (bus.busy_o[0] !== e_busy) begin n_fail++; $display("FAIL manual_busy c=%0d got=%b exp=%b", c, bus.busy_o[0], e_busy); end
      if (bus.di_o[0] !== e_di)     begin n_fail++; $display("FAIL manual_di c=%0d got=%b exp=%b", c, bus.di_o[0], e_di); end
      if (bus.rx_o[0] !== e_rx)     begin n_fail++; $display("FAIL manual_rx c=%0d got=%b exp=%b", c, bus.rx_o[0], e_rx); end
      $display("manual c=%0d de=%b ren=%b busy=%b di=%b rx=%b", c, bus.de_o[0], bus.ren_o[0], bus.busy_o[0], bus.di_o[0], bus.rx_o[0]);
    end
    bus.rx_enable_i[0] = 1'b0;
    step();
    step();
  endtask

  task automatic test_hold_retrigger();
    logic e_de, e_busy;
    bus.tx_enable_i[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.tx_enable_i[0] = (c < 8) || (c >= 10 && c < 15) || (c >= 21 && c < 30);
      bus.tx_i[0]        = 1'(c % 2);
      #1;
      e_de   = (c >= 5 && c <= 19) || (c >= 26 && c <= 34);
      e_busy = (c <= 38);
      n_checks += 3;
      if (bus.de_o[0] !== e_de)     begin n_fail++; $display("FAIL hold_de c=%0d got=%b exp=%b", c, bus.de_o[0], e_de); end
      if (bus.busy_o[0] !== e_busy) begin n_fail++; $display("FAIL hold_busy c=%0d got=%b exp=%b", c, bus.busy_o[0], e_busy); end
      if (bus.ren_o[0] !== 1'b1)    begin n_fail++; $display("FAIL hold_ren c=%0d got=%b exp=1", c, bus.ren_o[0]); end
      $display("hold c=%0d de=%b busy=%b ren=%b", c, bus.de_o[0], bus.busy_o[0], bus.ren_o[0]);
    end
    step();
  endtask

  task automatic test_auto();
    logic e_de, e_ren, e_busy, e_di, e_rx;
    bus.mode_auto_i[1] = 1'b1;
    bus.rx_enable_i[1] = 1'b1;
    bus.tx_enable_i[1] = 1'b0;
    bus.tx_i[1]        = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      step();
      bus.tx_i[1] = auto_tx(c);
      bus.ro_i[1] = 1'(c % 2);
      #1;
      e_de   = (c >= 25 && c <= 48);
      e_ren  = !((c >= 1 && c <= 20) || c >= 53);
      e_busy = (c >= 21 && c <= 52);
      e_di   = e_de ? auto_tx(c - 4) : 1'b1;
      e_rx   = e_ren ? 1'b1 : bus.ro_i[1];
      n_checks += 5;
      if (bus.de_o[1] !== e_de)     begin n_fail++; $display("FAIL auto_de c=%0d got=%b exp=%b", c, bus.de_o[1], e_de); end
      if (bus.ren_o[1] !== e_ren)   begin n_fail++; $display("FAIL auto_ren c=%0d got=%b exp=%b", c, bus.ren_o[1], e_ren); end
      if (bus.busy_o[1] !== e_busy) begin n_fail++; $display("FAIL auto_busy c=%0d got=%b exp=%b", c, bus.busy_o[1], e_busy); end
      if (bus.di_o[1] !== e_di)     begin n_fail++; $display("FAIL auto_di c=%0d got=%b exp=%b", c, bus.di_o[1], e_di); end
      if (bus.rx_o[1] !== e_rx)     begin n_fail++; $display("FAIL auto_rx c=%0d got=%b exp=%b", c, bus.rx_o[1], e_rx); end
      $display("auto c=%0d de=%b ren=%b busy=%b di=%b rx=%b", c, bus.de_o[1], bus.ren_o[1], bus.busy_o[1], bus.di_o[1], bus.rx_o[1]);
    end
  endtask

  task automatic test_independence_reset();
    logic e_di0;
    bus.mode_auto_i[0] = 1'b0;
    bus.tx_enable_i[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.tx_i[0] = 1'(c % 2);
      bus.ro_i[0] = 1'(c % 2);
      bus.ro_i[1] = ((c % 3) == 1);
      #1;
      e_di0 = (c >= 5) ? bus.tx_i[0] : 1'b1;
      n_checks += 8;
      if (bus.rx_o[1] !== bus.ro_i[1]) begin n_fail++; $display("FAIL indep_rx1 c=%0d got=%b exp=%b", c, bus.rx_o[1], bus.ro_i[1]); end
      if (bus.ren_o[1] !== 1'b0)  begin n_fail++; $display("FAIL indep_ren1 c=%0d got=%b exp=0", c, bus.ren_o[1]); end
      if (bus.de_o[1] !== 1'b0)   begin n_fail++; $display("FAIL indep_de1 c=%0d got=%b exp=0", c, bus.de_o[1]); end
      if (bus.busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL indep_busy1 c=%0d got=%b exp=0", c, bus.busy_o[1]); end
      if (bus.de_o[0] !== 1'(c >= 5)) begin n_fail++; $display("FAIL indep_de0 c=%0d got=%b exp=%b", c, bus.de_o[0], c >= 5); end
      if (bus.busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL indep_busy0 c=%0d got=%b exp=1", c, bus.busy_o[0]); end
      if (bus.rx_o[0] !== 1'b1)   begin n_fail++; $display("FAIL indep_rx0 c=%0d got=%b exp=1", c, bus.rx_o[0]); end
      if (bus.di_o[0] !== e_di0)  begin n_fail++; $display("FAIL indep_di0 c=%0d got=%b exp=%b", c, bus.di_o[0], e_di0); end
      $display("indep c=%0d de=%b busy=%b rx=%b di=%b ren=%b", c, bus.de_o, bus.busy_o, bus.rx_o, bus.di_o, bus.ren_o);
    end
    rst_i = 1'b1;
    step();
    #1;
    n_checks += 5;
    if (bus.de_o !== 2'b00)   begin n_fail++; $display("FAIL midrst_de got=%b exp=00", bus.de_o); end
    if (bus.busy_o !== 2'b00) begin n_fail++; $display("FAIL midrst_busy got=%b exp=00", bus.busy_o); end
    if (bus.ren_o !== 2'b11)  begin n_fail++; $display("FAIL midrst_ren got=%b exp=11", bus.ren_o); end
    if (bus.di_o !== 2'b11)   begin n_fail++; $display("FAIL midrst_di got=%b exp=11", bus.di_o); end
    if (bus.rx_o !== 2'b11)   begin n_fail++; $display("FAIL midrst_rx got=%b exp=11", bus.rx_o); end
    $display("midrst de=%b busy=%b ren=%b di=%b rx=%b", bus.de_o, bus.busy_o, bus.ren_o, bus.di_o, bus.rx_o);
    rst_i = 1'b0;
    bus.tx_enable_i = 2'b00;
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    test_reset();
    test_manual();
    test_hold_retrigger();
    test_auto();
    test_independence_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hd_xcvr_ctrl.md
Name: hd_xcvr_ctrl

Overview:
Parametrised multi-channel direction controller for half-duplex transceivers (RS-485 and similar), one instance serving NumChannels independent links. Each channel sequences receiver-enable and driver-enable with programmable turnaround and post-transmit hold, so receiver and driver are never active together. It adds an auto-direction mode, which derives the transmit request from UART line activity and delay-aligns the data. It sits between the UART block and the transceiver pins in the system clock domain.

Parameters:
NumChannels, 2, number of independent transceiver channels (>=1)
SwitchCycles, 5, clk_i cycles of turnaround with both drivers off (>=1)
EndCycles, 5, clk_i cycles the driver stays on after the transmit request drops (>=1)
AutoIdleCycles, 12, consecutive idle-high cycles that end an auto-mode transmission (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
mode_auto_i  in  NumChannels  1 = auto-direction, 0 = manual, per channel
tx_enable_i  in  NumChannels  manual-mode transmit request
rx_enable_i  in  NumChannels  receive request
tx_i  in  NumChannels  UART TX data, idle high
rx_o  out  NumChannels  UART RX data to the system
di_o  out  NumChannels  transceiver driver input
de_o  out  NumChannels  driver enable, active-high
ren_o  out  NumChannels  receiver enable, active-low
ro_i  in  NumChannels  transceiver receiver output
busy_o  out  NumChannels  channel is in any state other than OFF or RX

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Each channel has its own FSM, counter and delay line; there is no interaction between channels.
- States and outputs (de_o, ren_o, busy_o):
  - OFF: 0,1,0
  - RX: 0,0,0
  - TX_SETUP: 0,1,1
  - TX: 1,1,1
  - TX_HOLD: 1,1,1
  - RX_SETUP: 0,1,1
- de_o, ren_o and busy_o are decoded from the registered state only, with no combinational path from the inputs.
- Reset values: state OFF, counter 0, delay line all 1s, idle counter 0. Outputs: de_o=0, ren_o=1, di_o=1, rx_o=1, busy_o=0. Reset mid-operation returns to OFF on the next edge; de_o drops immediately.
- Mode latch: mode is latched into m_q on every cycle the channel is in OFF or RX. In any other state mode_auto_i is ignored.
- Delay line: SwitchCycles-deep shift register on tx_i; txd is tx_i delayed by exactly SwitchCycles cycles. It runs continuously.
- Transmit request treq:
  - Manual (m_q=0): treq = tx_enable_i.
  - Auto (m_q=1), in OFF/RX: treq = !tx_i.
  - Auto, in TX_SETUP/TX: treq = (idle_cnt < AutoIdleCycles). idle_cnt counts consecutive cycles of txd==1, clears on txd==0 and on entry to TX_SETUP, and saturates at AutoIdleCycles.
- Transitions (treq has priority over rx_enable_i):
  - OFF: treq -> TX_SETUP; else rx_enable_i -> RX.
  - RX: treq -> TX_SETUP; else !rx_enable_i -> OFF.
  - TX_SETUP: counter loads SwitchCycles-1 on entry and decrements; at 0 -> TX. The request is not re-checked, so setup always completes.
  - TX: !treq -> TX_HOLD with counter loaded to EndCycles-1.
  - TX_HOLD: treq -> TX, hold abandoned. Else at counter 0 -> RX_SETUP with counter loaded to SwitchCycles-1.
  - RX_SETUP: treq -> TX_SETUP with counter reloaded. Else at counter 0 -> RX if rx_enable_i, otherwise OFF.
- Counter width: $clog2(max(SwitchCycles, EndCycles)+1). The counter never wraps.
- di_o:
  - In TX or TX_HOLD: tx_i (manual) or txd (auto).
  - In all other states: 1.
  - Combinational mux from a registered select.
- rx_o: ro_i in RX, otherwise 1.
- Latency:
  - Request to de_o=1 is SwitchCycles+1 edges.
  - Manual request drop to de_o=0 is EndCycles+1 edges.
  - de_o=0 to ren_o=0 is SwitchCycles edges.

Test Plan:
- Reset, NumChannels=2, Switch=4, End=4, Idle=10: assert rst_i with random inputs -> de_o=00, ren_o=11, di_o=11, rx_o=11, busy_o=00 on the first edge.
- Manual ch0, rx_enable=1 at cycle 0 -> ren_o=0 at 1. tx_enable rises at 10 -> ren_o=1 at 11, de_o=1 at 15, di_o follows tx_i. tx_enable falls at 30 -> de_o=0 at 35, ren_o=0 at 39, rx_o tracks ro_i from 39.
- Hold retrigger: tx_enable low for 2 cycles during TX -> de_o never drops, state returns TX, busy_o stays 1. Then tx_enable re-rises during RX_SETUP -> TX_SETUP, de_o=1 exactly 5 edges later.
- Auto ch1, 10-bit frame starting at cycle 20 (start bit low) -> de_o=1 at 25, di_o equals tx_i delayed 4, first di_o=0 at 25. Frame ends high at 30 -> de_o=0 at 30+4+10+1+4=49, ren_o=0 at 53.
- Independence and reset: ch0 manual TX while ch1 auto RX sees ro_i toggling -> ch1 rx_o mirrors ro_i, ch0 unaffected. rst_i pulse during ch0 TX -> de_o=0 next edge, busy_o=0.
